// File: rtl/mult_scheduler_if.sv
// Bundle of requester-side and multiplier-side signals for mult_scheduler.
// The scheduler takes the slave modport; clients plus the multiplier sit on master.
interface mult_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] op_a;
    logic [N_REQ*WIDTH-1:0] op_b;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [2*WIDTH-1:0]     result;
    logic                   busy;
    logic                   mul_start;
    logic [WIDTH-1:0]       mul_multiplicand;
    logic [WIDTH-1:0]       mul_multiplier;
    logic [2*WIDTH-1:0]     mul_product;

    modport slave (
        input  req, op_a, op_b, mul_product,
        output gnt, done, result, busy, mul_start, mul_multiplicand, mul_multiplier
    );

    modport master (
        output req, op_a, op_b, mul_product,
        input  gnt, done, result, busy, mul_start, mul_multiplicand, mul_multiplier
    );
endinterface

// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one external shift-add multiplier among N_REQ clients.
// Optional MULT_SCHED_ZERO_BYPASS_EN: zero operands skip the multiplier and finish at once.
module mult_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int MUL_LAT = 5
) (
    input  logic            clk,
    input  logic            rst,
    mult_scheduler_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      idx, last, win;
    logic               found;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q, b_q, sel_a, sel_b;
    logic [2*WIDTH-1:0] result_q;
    logic [N_REQ-1:0]   onehot;
    logic               last_cycle;

    // Search starts just after the previous winner, so a repeat requester ranks last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && bus.req[(int'(last) + k) % N_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(last) + k) % N_REQ);
            end
        end
    end

    assign sel_a      = bus.op_a[win*WIDTH +: WIDTH];
    assign sel_b      = bus.op_b[win*WIDTH +: WIDTH];
    assign last_cycle = (cnt == CW'(MUL_LAT - 1));

`ifdef MULT_SCHED_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (found) begin
`ifdef MULT_SCHED_ZERO_BYPASS_EN
                    state_n = zero_op ? DONE : RUN;
`else
                    state_n = RUN;
`endif
                end
            end
            RUN:     if (last_cycle) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            last     <= IW'(N_REQ - 1);
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        idx <= win;
                        a_q <= sel_a;
                        b_q <= sel_b;
                        cnt <= '0;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
                        if (zero_op) begin
                            result_q <= '0;
                            last     <= win;
                        end
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (last_cycle) begin
                        result_q <= bus.mul_product;
                        last     <= idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign onehot               = N_REQ'(1) << idx;
    assign bus.gnt              = (state != IDLE) ? onehot : '0;
    assign bus.done             = (state == DONE) ? onehot : '0;
    assign bus.busy             = (state != IDLE);
    assign bus.mul_start        = (state == RUN);
    assign bus.mul_multiplicand = a_q;
    assign bus.mul_multiplier   = b_q;
    assign bus.result           = result_q;
endmodule

// File: tb/tb_mult_scheduler.sv
// Scoreboard bench for mult_scheduler with a shift-add multiplier model that needs
// WIDTH start-high cycles before its product is valid.
module tb_mult_scheduler;
    localparam int N   = 4;
    localparam int W   = 4;
    localparam int LAT = 5;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
    localparam int ZLAT = 0;
    localparam int ZST  = 0;
`else
    localparam int ZLAT = LAT;
    localparam int ZST  = LAT;
`endif

    typedef struct {
        int idx;
        int res;
        int lat;
        int st;
    } exp_t;

    logic clk, rst;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [3:0] mcnt;

    mult_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

    mult_scheduler #(.N_REQ(N), .WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: product is garbage until start has been high WIDTH cycles.
    always @(posedge clk) begin
        if (!bus.mul_start)     mcnt <= 4'd0;
        else if (mcnt != 4'hF)  mcnt <= mcnt + 4'd1;
    end
    assign bus.mul_product = (mcnt >= 4'(W)) ?
        (8'(bus.mul_multiplicand) * 8'(bus.mul_multiplier)) : 8'hEE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_job(input int i, input int r, input int l, input int s);
        exp_t e;
        e.idx = i; e.res = r; e.lat = l; e.st = s;
        sb.push_back(e);
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        bus.op_a[i*W +: W] = a;
        bus.op_b[i*W +: W] = b;
    endtask

    task automatic wait_done(input logic [3:0] mask, input string name);
        int t = 0;
        while (1) begin
            @(negedge clk);
            if ((bus.done & mask) != 0) break;
            t++;
            if (t > 60) begin
                n_cmp++; n_err++;
                $display("FAIL %s: no done within 60 cycles", name);
                break;
            end
        end
    endtask

    task automatic wait_gnt(input logic [3:0] mask, input string name);
        int t = 0;
        while (1) begin
            @(negedge clk);
            if ((bus.gnt & mask) != 0) break;
            t++;
            if (t > 60) begin
                n_cmp++; n_err++;
                $display("FAIL %s: no grant within 60 cycles", name);
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops one expected job per done pulse and checks timing and data.
    initial begin
        int   cyc = 0, rise_cyc = 0, starts = 0;
        logic [3:0] prev_gnt = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_gnt = '0;
            end else begin
                if (bus.gnt != 0 && prev_gnt == 0) begin
                    rise_cyc = cyc;
                    starts   = 0;
                end
                if (bus.mul_start) starts++;
                if (bus.done != 0) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL done_unexpected: done=%b with no job expected", bus.done);
                    end else begin
                        e = sb.pop_front();
                        check("done_onehot", 32'(bus.done), 32'(1 << e.idx));
                        check("gnt_in_done", 32'(bus.gnt), 32'(1 << e.idx));
                        check("result", 32'(bus.result), 32'(e.res));
                        check("done_latency", 32'(cyc - rise_cyc), 32'(e.lat));
                        check("mul_start_cycles", 32'(starts), 32'(e.st));
                    end
                end
                prev_gnt = bus.gnt;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        time t0, t1;
        rst = 1'b1;
        bus.req = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_mul_start", 32'(bus.mul_start), 0);
        check("rst_mul_a", 32'(bus.mul_multiplicand), 0);
        check("rst_mul_b", 32'(bus.mul_multiplier), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single job 2x3
        expect_job(0, 6, LAT, LAT);
        set_op(0, 2, 3);
        bus.req[0] = 1'b1;
        wait_done(4'b0001, "single");
        bus.req[0] = 1'b0;
        @(negedge clk);
        check("single_idle_busy", 32'(bus.busy), 0);
        check("single_idle_gnt", 32'(bus.gnt), 0);

        // Contention 9x9 on 0 and 3x4 on 2, from fresh reset
        pulse_reset();
        expect_job(0, 81, LAT, LAT);
        expect_job(2, 12, LAT, LAT);
        set_op(0, 9, 9);
        set_op(2, 3, 4);
        bus.req = 4'b0101;
        wait_done(4'b0001, "contend0");
        t0 = $time;
        bus.req[0] = 1'b0;
        wait_done(4'b0100, "contend2");
        t1 = $time;
        bus.req[2] = 1'b0;
        check("contend_spacing", 32'((t1 - t0) / 10), 32'(LAT + 2));

        // Fairness: all held high, two full rounds
        pulse_reset();
        for (int i = 0; i < N; i++) set_op(i, 4'(i + 1), 4'(i + 2));
        for (int r = 0; r < 2; r++) begin
            expect_job(0, 2, LAT, LAT);
            expect_job(1, 6, LAT, LAT);
            expect_job(2, 12, LAT, LAT);
            expect_job(3, 20, LAT, LAT);
        end
        bus.req = 4'hF;
        for (int j = 0; j < 8; j++) wait_done(4'hF, "fair");
        bus.req = '0;

        // Operand stability: op_a[1] changes mid-job
        expect_job(1, 10, LAT, LAT);
        set_op(1, 5, 2);
        bus.req[1] = 1'b1;
        wait_gnt(4'b0010, "stab_gnt");
        @(negedge clk);
        set_op(1, 15, 2);
        @(negedge clk);
        check("stab_mul_a", 32'(bus.mul_multiplicand), 5);
        wait_done(4'b0010, "stab");
        bus.req[1] = 1'b0;

        // Reset on the third RUN cycle, then 0 and 2 compete
        set_op(0, 4, 4);
        bus.req[0] = 1'b1;
        wait_gnt(4'b0001, "rstmid_gnt");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_mul_start", 32'(bus.mul_start), 0);
        check("rstmid_gnt", 32'(bus.gnt), 0);
        check("rstmid_done", 32'(bus.done), 0);
        check("rstmid_result", 32'(bus.result), 0);
        expect_job(0, 16, LAT, LAT);
        expect_job(2, 15, LAT, LAT);
        set_op(2, 3, 5);
        bus.req[2] = 1'b1;
        rst = 1'b0;
        wait_done(4'b0001, "rstmid0");
        bus.req[0] = 1'b0;
        wait_done(4'b0100, "rstmid2");
        bus.req[2] = 1'b0;

        // Zero operand 0x7 on requester 3
        expect_job(3, 0, ZLAT, ZST);
        set_op(3, 0, 7);
        bus.req[3] = 1'b1;
        wait_done(4'b1000, "zero");
        bus.req[3] = 1'b0;

        // Largest product 15x15
        expect_job(1, 225, LAT, LAT);
        set_op(1, 15, 15);
        bus.req[1] = 1'b1;
        wait_done(4'b0010, "max");
        bus.req[1] = 1'b0;

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
